// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT frame sequencer.
// Word widths, state encoding and word indices into the stage-1/stage-2 result buses.
// Every word is one IEEE-754 single carried bit-exact; nothing here does arithmetic.
package fft8_pkg;

  localparam int WORD     = 32;
  localparam int NPTS     = 8;
  localparam int S1_WORDS = 10;
  localparam int S2_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    OUT  = 3'd4
  } state_e;

  // Stage-1 result words (also the stage-2 operand order)
  localparam int W_P    = 0;
  localparam int W_B    = 1;
  localparam int W_DBAR = 2;
  localparam int W_R    = 3;
  localparam int W_D    = 4;
  localparam int W_T    = 5;
  localparam int W_F    = 6;
  localparam int W_HBAR = 7;
  localparam int W_V    = 8;
  localparam int W_H    = 9;

  // Stage-2 result words: bin k real part at 2k, imaginary part at 2k+1
  localparam int X0R = 0;
  localparam int X0I = 1;
  localparam int X1R = 2;
  localparam int X1I = 3;
  localparam int X2R = 4;
  localparam int X2I = 5;
  localparam int X3R = 6;
  localparam int X3I = 7;
  localparam int X4R = 8;
  localparam int X4I = 9;
  localparam int X5R = 10;
  localparam int X5I = 11;
  localparam int X6R = 12;
  localparam int X6I = 13;
  localparam int X7R = 14;
  localparam int X7I = 15;

  // Pick one 32-bit word out of a stage-2 sized bus
  function automatic logic [WORD-1:0] s2_word(input logic [S2_WORDS*WORD-1:0] v,
                                              input int idx);
    return v[WORD*idx +: WORD];
  endfunction

endpackage

// File: rtl/fft8_settle_timer.sv
// Settle window timer: loadable down-counter with a one-cycle done pulse.
// Latency: done is high in the cycle the count reaches 0, i.e. load_val+1 cycles after load.
// Backpressure: none; clr and load take effect on the next edge, clr has priority.
module fft8_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  // Next count: clear beats load, load beats counting; stop after reaching zero
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clr) begin
      cnt_d = 4'd0;
      run_d = 1'b0;
    end else if (load) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 4'd0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == 4'd0);

endmodule

// File: rtl/fft8_seq.sv
// Frame sequencer for the 8-point FP FFT: buffer samples, settle stage 1 then stage 2, stream bins.
// Latency: first bin valid 2*SETTLE edges after the last sample handshake.
// Backpressure: in_ready low from S1 until the last bin leaves; out_* hold while out_ready is low.
module fft8_seq
  import fft8_pkg::*;
#(
  // Stage settle window in cycles, 1..15; must match the multicycle constraint on the stage paths
  parameter int unsigned SETTLE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WORD-1:0]           in_data,
  output logic                      in_ready,
  output logic [NPTS*WORD-1:0]      s1_x,
  input  logic [S1_WORDS*WORD-1:0]  s1_y,
  output logic [S1_WORDS*WORD-1:0]  s2_in,
  input  logic [S2_WORDS*WORD-1:0]  s2_out,
  output logic                      out_valid,
  output logic [WORD-1:0]           out_re,
  output logic [WORD-1:0]           out_im,
  output logic [2:0]                out_idx,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e                     state_q, state_d;
  logic [2:0]                 wptr_q, wptr_d;
  logic [2:0]                 bin_q, bin_d;
  logic [NPTS*WORD-1:0]       samp_q, samp_d;
  logic [S1_WORDS*WORD-1:0]   mid_q, mid_d;
  logic [S2_WORDS*WORD-1:0]   res_q, res_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;
  logic [WORD-1:0]            out_re_q, out_re_d;
  logic [WORD-1:0]            out_im_q, out_im_d;

  logic                       in_hs;
  logic                       out_hs;
  logic                       tmr_load;
  logic                       tmr_done;
  logic [2:0]                 nb;

  assign in_hs  = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;
  assign nb     = bin_q + 3'd1;

  // One timer serves both stages: reloaded on entry to S1 and again on entry to S2
  fft8_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (tmr_load),
    .load_val (SETTLE_M1),
    .done     (tmr_done)
  );

  // Next-state and datapath capture; flush overrides everything and drops any handshake
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    bin_d       = bin_q;
    samp_d      = samp_q;
    mid_d       = mid_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    tmr_load    = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      wptr_d      = 3'd0;
      bin_d       = 3'd0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (in_hs) begin
            samp_d[WORD*int'(wptr_q) +: WORD] = in_data;
            wptr_d = wptr_q + 3'd1;
            if (state_q == IDLE) begin
              state_d = LOAD;
            end else if (wptr_q == 3'd7) begin
              state_d  = S1;
              tmr_load = 1'b1;
            end
          end
        end
        S1: begin
          if (tmr_done) begin
            mid_d    = s1_y;
            state_d  = S2;
            tmr_load = 1'b1;
          end
        end
        S2: begin
          if (tmr_done) begin
            res_d       = s2_out;
            state_d     = OUT;
            bin_d       = 3'd0;
            out_valid_d = 1'b1;
            out_re_d    = s2_word(s2_out, X0R);
            out_im_d    = s2_word(s2_out, X0I);
          end
        end
        OUT: begin
          if (out_hs) begin
            if (bin_q == 3'd7) begin
              state_d     = IDLE;
              bin_d       = 3'd0;
              out_valid_d = 1'b0;
            end else begin
              bin_d    = nb;
              out_re_d = s2_word(res_q, 2 * int'(nb));
              out_im_d = s2_word(res_q, 2 * int'(nb) + 1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  // All sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= 3'd0;
      bin_q       <= 3'd0;
      samp_q      <= '0;
      mid_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      bin_q       <= bin_d;
      samp_q      <= samp_d;
      mid_q       <= mid_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Stage inputs come straight from registers so they stay still for the whole window
  assign s1_x      = samp_q;
  assign s2_in     = mid_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = bin_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fft8_seq.sv
// Bench for fft8_seq: behavioural stage models, random and directed frames, flush and reset aborts.
module tb_fft8_seq;

  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [255:0] s1_x;
  logic [319:0] s1_y;
  logic [319:0] s2_in;
  logic [511:0] s2_out;
  logic         out_valid;
  logic [31:0]  out_re;
  logic [31:0]  out_im;
  logic [2:0]   out_idx;
  logic         out_ready;
  logic         busy;

  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  int unsigned  cyc_hs = 0;
  int           acc = 0;
  bit           ramp = 1'b0;
  logic [511:0] ramp_vec;

  fft8_seq #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .s1_x      (s1_x),
    .s1_y      (s1_y),
    .s2_in     (s2_in),
    .s2_out    (s2_out),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Samples actually accepted (a flushed handshake is dropped)
  always @(posedge clk) if (rst_n && in_valid && in_ready && !flush) acc <= acc + 1;

  // Stage-1 network stand-in: depends on the samples and on the cycle, so it moves every cycle
  function automatic logic [319:0] s1_model(input logic [255:0] x, input int unsigned c);
    logic [319:0] y;
    for (int i = 0; i < 10; i++)
      y[32*i +: 32] = x[32*(i%8) +: 32] ^ (c * 32'h9E3779B1 + 32'(i));
    return y;
  endfunction

  // Stage-2 network stand-in: a fixed function of its operands
  function automatic logic [511:0] s2_model(input logic [319:0] m);
    logic [511:0] z;
    for (int j = 0; j < 16; j++)
      z[32*j +: 32] = m[32*(j%10) +: 32] + 32'h01010101 * 32'(j);
    return z;
  endfunction

  assign s1_y   = s1_model(s1_x, cyc);
  assign s2_out = ramp ? ramp_vec : s2_model(s2_in);

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one sample and return at the negedge after it was taken
  task automatic push(input logic [31:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (in_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk("in_ready_wait", 512'(t), 512'd0);
    cyc_hs = cyc;
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] x;
    for (int n = 0; n < 8; n++) x[32*n +: 32] = $urandom;
    return x;
  endfunction

  // Full frame: load, watch both settle windows, drain bins (optional stall or flush at a bin)
  task automatic run_frame(input logic [255:0] x, input bit hold, input int stall_k,
                           input int flush_k, input bit use_ramp);
    logic [319:0] em;
    logic [511:0] er;
    int base;
    ramp = use_ramp;
    base = acc;
    for (int n = 0; n < 8; n++) push(x[32*n +: 32]);
    if (!hold) in_valid = 1'b0;
    em = s1_model(x, cyc_hs + SETTLE);
    er = use_ramp ? ramp_vec : s2_model(em);
    for (int k = 0; k < 2 * SETTLE; k++) begin
      chk("busy_run", 512'(busy), 512'd1);
      chk("in_ready_run", 512'(in_ready), 512'd0);
      chk("out_valid_early", 512'(out_valid), 512'd0);
      chk("s1_x_hold", 512'(s1_x), 512'(x));
      if (k >= SETTLE) chk("s2_in_mid", 512'(s2_in), 512'(em));
      @(negedge clk);
    end
    chk("out_valid_first", 512'(out_valid), 512'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("out_idx", 512'(out_idx), 512'(k));
      chk("out_re", 512'(out_re), 512'(er[64*k +: 32]));
      chk("out_im", 512'(out_im), 512'(er[64*k+32 +: 32]));
      chk("in_ready_out", 512'(in_ready), 512'd0);
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", 512'(out_valid), 512'd1);
          chk("stall_idx", 512'(out_idx), 512'(k));
          chk("stall_re", 512'(out_re), 512'(er[64*k +: 32]));
          chk("stall_im", 512'(out_im), 512'(er[64*k+32 +: 32]));
        end
        out_ready = 1'b1;
      end
      if (k == flush_k) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_out_valid", 512'(out_valid), 512'd0);
        chk("flush_in_ready", 512'(in_ready), 512'd1);
        chk("flush_busy", 512'(busy), 512'd0);
        return;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("idle_out_valid", 512'(out_valid), 512'd0);
    chk("idle_busy", 512'(busy), 512'd0);
    chk("idle_in_ready", 512'(in_ready), 512'd1);
    chk("accepted", 512'(acc - base), 512'd8);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_out_re", 512'(out_re), 512'd0);
    chk("rst_out_im", 512'(out_im), 512'd0);
    chk("rst_out_idx", 512'(out_idx), 512'd0);
    chk("rst_s1_x", 512'(s1_x), 512'd0);
    chk("rst_s2_in", 512'(s2_in), 512'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [255:0] x;

    for (int j = 0; j < 16; j++) ramp_vec[32*j +: 32] = 32'hA000_0000 + 32'(j);
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs();

    // Ramp frame with fixed stage-2 pattern
    for (int n = 0; n < 8; n++) x[32*n +: 32] = 32'h3F80_0000 + 32'(n);
    run_frame(x, 1'b0, -1, -1, 1'b1);

    // Random frame with output stall at bin 3
    run_frame(rand_frame(), 1'b0, 3, -1, 1'b0);

    // in_valid held high through a frame, next frame follows right after bin 7
    run_frame(rand_frame(), 1'b1, -1, -1, 1'b0);
    run_frame(rand_frame(), 1'b0, -1, -1, 1'b0);

    // Flush after 5 samples; the simultaneous sample is dropped
    x = rand_frame();
    for (int n = 0; n < 5; n++) push(x[32*n +: 32]);
    flush    = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flushL_in_ready", 512'(in_ready), 512'd1);
    chk("flushL_busy", 512'(busy), 512'd0);
    chk("flushL_out_valid", 512'(out_valid), 512'd0);

    // Special values pass bit-exact: NaN, -0, +0, denormals, infinity
    x = {32'h7FC0_0001, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001,
         32'h807F_FFFF, 32'h7F80_0000, 32'hFFFF_FFFF, 32'h3F80_0000};
    run_frame(x, 1'b0, -1, -1, 1'b0);

    // Flush during output at bin 2, then a clean frame
    run_frame(rand_frame(), 1'b0, -1, 2, 1'b0);
    run_frame(rand_frame(), 1'b0, -1, -1, 1'b0);

    // Asynchronous reset while in S2
    x = rand_frame();
    ramp = 1'b0;
    for (int n = 0; n < 8; n++) push(x[32*n +: 32]);
    in_valid = 1'b0;
    repeat (SETTLE + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * SETTLE + 4; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 512'(out_valid), 512'd0);
      chk("post_rst_busy", 512'(busy), 512'd0);
    end
    run_frame(rand_frame(), 1'b0, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
